// File: rtl/axis_parity_merge.sv
// Merges the odd/even AXI-Stream channels onto one master, packet-atomic, tuser = source (1 odd, 0 even).
// Latency: one arbitration bubble per packet, then 1 cycle slave beat to registered master beat.
// Backpressure: granted slave tready = !m_tvalid || m_tready; the ungranted channel never sees tready.
// Optional macro AXIS_PARITY_MERGE_PKT_CNT_EN adds per-channel completed-packet counters.
module axis_parity_merge #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  a_clk,
    input  logic                  axis_aresetn,
    input  logic                  axis_s_tvalid_odd,
    input  logic [DATA_WIDTH-1:0] axis_s_tdata_odd,
    input  logic                  axis_s_tlast_odd,
    output logic                  axis_s_tready_odd,
    input  logic                  axis_s_tvalid_even,
    input  logic [DATA_WIDTH-1:0] axis_s_tdata_even,
    input  logic                  axis_s_tlast_even,
    output logic                  axis_s_tready_even,
    output logic                  axis_m_tvalid,
    output logic [DATA_WIDTH-1:0] axis_m_tdata,
    output logic                  axis_m_tlast,
    output logic                  axis_m_tuser,
    input  logic                  axis_m_tready
`ifdef AXIS_PARITY_MERGE_PKT_CNT_EN
    ,
    output logic [15:0]           pkt_cnt_odd,
    output logic [15:0]           pkt_cnt_even
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PASS_ODD  = 2'd1,
        ST_PASS_EVEN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant_odd;
    logic                  w_last_grant_odd_nxt;

    logic                  r_m_tvalid;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tlast;
    logic                  r_m_tuser;

    logic                  w_load_en;
    logic                  w_tready_odd;
    logic                  w_tready_even;
    logic                  w_acc_odd;
    logic                  w_acc_even;

    // The output register can take a new beat when empty or being drained this cycle.
    assign w_load_en  = !r_m_tvalid || axis_m_tready;
    assign w_acc_odd  = axis_s_tvalid_odd  && w_tready_odd;
    assign w_acc_even = axis_s_tvalid_even && w_tready_even;

    // Arbitration and grant: ready comes only from state and the output register, never from tvalid.
    always_comb begin
        w_state_nxt          = r_state;
        w_last_grant_odd_nxt = r_last_grant_odd;
        w_tready_odd         = 1'b0;
        w_tready_even        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (axis_s_tvalid_odd && axis_s_tvalid_even) begin
                    w_state_nxt = r_last_grant_odd ? ST_PASS_EVEN : ST_PASS_ODD;
                end else if (axis_s_tvalid_odd) begin
                    w_state_nxt = ST_PASS_ODD;
                end else if (axis_s_tvalid_even) begin
                    w_state_nxt = ST_PASS_EVEN;
                end
            end
            ST_PASS_ODD: begin
                w_tready_odd = w_load_en;
                if (axis_s_tvalid_odd && w_load_en && axis_s_tlast_odd) begin
                    w_state_nxt          = ST_IDLE;
                    w_last_grant_odd_nxt = 1'b1;
                end
            end
            ST_PASS_EVEN: begin
                w_tready_even = w_load_en;
                if (axis_s_tvalid_even && w_load_en && axis_s_tlast_even) begin
                    w_state_nxt          = ST_IDLE;
                    w_last_grant_odd_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset points last grant at odd so even wins the first tie.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state          <= ST_IDLE;
            r_last_grant_odd <= 1'b1;
        end else begin
            r_state          <= w_state_nxt;
            r_last_grant_odd <= w_last_grant_odd_nxt;
        end
    end

    // Output register: load on an accepted slave beat, otherwise drop valid once the sink takes it.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
        end else if (w_acc_odd) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= axis_s_tdata_odd;
            r_m_tlast  <= axis_s_tlast_odd;
            r_m_tuser  <= 1'b1;
        end else if (w_acc_even) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= axis_s_tdata_even;
            r_m_tlast  <= axis_s_tlast_even;
            r_m_tuser  <= 1'b0;
        end else if (axis_m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign axis_s_tready_odd  = w_tready_odd;
    assign axis_s_tready_even = w_tready_even;
    assign axis_m_tvalid      = r_m_tvalid;
    assign axis_m_tdata       = r_m_tdata;
    assign axis_m_tlast       = r_m_tlast;
    assign axis_m_tuser       = r_m_tuser;

`ifdef AXIS_PARITY_MERGE_PKT_CNT_EN
    logic [15:0] r_pkt_cnt_odd;
    logic [15:0] r_pkt_cnt_even;

    // Count packets as they leave on the master side; counters wrap naturally.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_pkt_cnt_odd  <= 16'd0;
            r_pkt_cnt_even <= 16'd0;
        end else if (r_m_tvalid && axis_m_tready && r_m_tlast) begin
            if (r_m_tuser) begin
                r_pkt_cnt_odd  <= r_pkt_cnt_odd + 16'd1;
            end else begin
                r_pkt_cnt_even <= r_pkt_cnt_even + 16'd1;
            end
        end
    end

    assign pkt_cnt_odd  = r_pkt_cnt_odd;
    assign pkt_cnt_even = r_pkt_cnt_even;
`endif

endmodule
